// File: rtl/scoreboard_reg_file.sv
// Register file with 2 read ports, 1 write port, pending-write scoreboard and sweep clear.
// Optional same-cycle write-to-read forwarding is compiled in with `define REG_BYPASS_EN.
module scoreboard_reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              clr_req,
  output logic              clr_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]   pend;
  logic               clr_busy_q;

  assign clr_busy = clr_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend       <= '0;
      idx        <= '0;
      state      <= IDLE;
      clr_busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            regs[wr_dst] <= wr_data;
            pend[wr_dst] <= 1'b0;
          end
          // Issue is applied after the write so a newer producer keeps the bit set
          if (iss_en) pend[iss_dst] <= 1'b1;
          if (clr_req) begin
            state      <= SWEEP;
            idx        <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          regs[idx] <= '0;
          pend[idx] <= 1'b0;
          idx       <= idx + 1'b1;
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state      <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_BYPASS_EN
  logic fwd_ok, iss_same, hit_1, hit_2;
  assign fwd_ok   = wr_en && !clr_busy_q;
  assign iss_same = iss_en && (iss_dst == wr_dst);
  assign hit_1    = fwd_ok && (wr_dst == rd_addr_1);
  assign hit_2    = fwd_ok && (wr_dst == rd_addr_2);
  // A forwarded write retires the register unless a new issue re-marks it now
  assign data_1 = hit_1 ? wr_data  : regs[rd_addr_1];
  assign data_2 = hit_2 ? wr_data  : regs[rd_addr_2];
  assign busy_1 = hit_1 ? iss_same : pend[rd_addr_1];
  assign busy_2 = hit_2 ? iss_same : pend[rd_addr_2];
`else
  assign data_1 = regs[rd_addr_1];
  assign data_2 = regs[rd_addr_2];
  assign busy_1 = pend[rd_addr_1];
  assign busy_2 = pend[rd_addr_2];
`endif

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Self-checking bench for scoreboard_reg_file: directed plan plus random traffic vs a behavioural model.
module tb_scoreboard_reg_file;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr_1, rd_addr_2, wr_dst, iss_dst;
  logic [DW-1:0] data_1, data_2, wr_data;
  logic          busy_1, busy_2, wr_en, iss_en, clr_req, clr_busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: contents, pending flags, and how many sweep cycles remain
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];
  int            m_sweep_left;

  scoreboard_reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .data_1(data_1), .data_2(data_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
    .iss_en(iss_en), .iss_dst(iss_dst),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [AW-1:0] a);
`ifdef REG_BYPASS_EN
    return wr_en && (m_sweep_left == 0) && (wr_dst == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return m_hit(a) ? wr_data : m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_hit(a) ? (iss_en && iss_dst == wr_dst) : m_pend[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_sweep_left = 0;
    end else if (m_sweep_left > 0) begin
      m_regs[DEPTH - m_sweep_left] = '0;
      m_pend[DEPTH - m_sweep_left] = 0;
      m_sweep_left--;
    end else begin
      if (wr_en) begin m_regs[wr_dst] = wr_data; m_pend[wr_dst] = 0; end
      if (iss_en) m_pend[iss_dst] = 1;
      if (clr_req) m_sweep_left = DEPTH;
    end
  end

  // Single compare process: outputs are sampled mid-cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_1", data_1, exp_data(rd_addr_1));
      chk("data_2", data_2, exp_data(rd_addr_2));
      chk("busy_1", busy_1, exp_busy(rd_addr_1));
      chk("busy_2", busy_2, exp_busy(rd_addr_2));
      chk("clr_busy", clr_busy, m_sweep_left > 0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; iss_en = 0; clr_req = 0;
    wr_dst = '0; wr_data = '0; iss_dst = '0;
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_dst = AW'(i); wr_data = DW'(16'h1111 * (i + 1));
      cyc();
    end
    idle();
  endtask

  task automatic all_zero(input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_1 = AW'(a); rd_addr_2 = AW'(DEPTH - 1 - a);
      @(negedge clk);
      chk({nm, "_d1"}, data_1, 0);
      chk({nm, "_d2"}, data_2, 0);
      chk({nm, "_b1"}, busy_1, 0);
      chk({nm, "_b2"}, busy_2, 0);
      cyc();
    end
  endtask

  initial begin
    int n;
    idle();
    rd_addr_1 = '0; rd_addr_2 = '0;
    rst = 1;
    cyc();
    rst = 0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_clr_busy", clr_busy, 0);
    cyc();
    all_zero("rst");

    // Write with same-cycle read
    wr_en = 1; wr_dst = 3'd5; wr_data = 16'hBEEF; rd_addr_1 = 3'd5;
    @(negedge clk);
`ifdef REG_BYPASS_EN
    chk("wr_same_cycle", data_1, 16'hBEEF);
`else
    chk("wr_same_cycle", data_1, 16'h0000);
`endif
    cyc(); idle();
    @(negedge clk);
    chk("wr_next_cycle", data_1, 16'hBEEF);
    chk("model_r5", m_regs[5], 16'hBEEF);
    cyc();

    // Issue then commit
    iss_en = 1; iss_dst = 3'd3; rd_addr_2 = 3'd3;
    cyc(); idle();
    @(negedge clk);
    chk("iss_busy", busy_2, 1);
    cyc();
    wr_en = 1; wr_dst = 3'd3; wr_data = 16'h1234;
    cyc(); idle();
    @(negedge clk);
    chk("commit_busy", busy_2, 0);
    chk("commit_data", data_2, 16'h1234);
    cyc();

    // Issue and write to the same register in one cycle
    iss_en = 1; iss_dst = 3'd2; wr_en = 1; wr_dst = 3'd2; wr_data = 16'h00AA; rd_addr_1 = 3'd2;
    cyc(); idle();
    @(negedge clk);
    chk("iss_wr_data", data_1, 16'h00AA);
    chk("iss_wr_busy", busy_1, 1);
    chk("model_p2", m_pend[2], 1);
    cyc();

    // Full sweep with a write attempt that must be dropped
    load_all();
    rd_addr_1 = 3'd7;
    @(negedge clk);
    chk("load_r7", data_1, 16'h8888);
    cyc();
    clr_req = 1;
    cyc(); clr_req = 0;
    n = 0;
    while (clr_busy && n < 20) begin
      n++;
      if (n == 1) begin wr_en = 1; wr_dst = 3'd6; wr_data = 16'hFFFF; end
      else idle();
      cyc();
    end
    idle();
    chk("sweep_len", n, DEPTH);
    all_zero("swept");

    // Reset in sweep cycle 4, then a fresh sweep
    load_all();
    clr_req = 1;
    cyc(); clr_req = 0;
    cyc(); cyc(); cyc();
    rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    chk("midrst_clr_busy", clr_busy, 0);
    chk("model_sweep_left", m_sweep_left, 0);
    cyc();
    all_zero("midrst");
    clr_req = 1;
    cyc(); clr_req = 0;
    n = 0;
    while (clr_busy && n < 20) begin n++; cyc(); end
    chk("fresh_sweep_len", n, DEPTH);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      clr_req   = ($urandom_range(0, 39) == 0);
      wr_en     = $urandom_range(0, 1);
      iss_en    = ($urandom_range(0, 9) < 4);
      wr_dst    = AW'($urandom);
      iss_dst   = ($urandom_range(0, 3) == 0) ? wr_dst : AW'($urandom);
      wr_data   = DW'($urandom);
      rd_addr_1 = ($urandom_range(0, 2) == 0) ? wr_dst : AW'($urandom);
      rd_addr_2 = AW'($urandom);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
